// File: rtl/uart_apb_regfile_pkg.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile_pkg
//   Shared definitions for the UART APB register file: register offsets
//   (PADDR[7:0]), CTRL/STATUS/INTSTAT bit indices and FRAME field positions.
// ----------------------------------------------------------------------------
package uart_apb_regfile_pkg;

  typedef enum logic [7:0] {
    REG_TXDATA  = 8'h00,
    REG_RXDATA  = 8'h01,
    REG_BAUD    = 8'h02,
    REG_CTRL    = 8'h03,
    REG_FRAME   = 8'h04,
    REG_STATUS  = 8'h05,
    REG_INTSTAT = 8'h06,
    REG_INTMASK = 8'h07,
    REG_LEVEL   = 8'h08
  } reg_addr_e;

  // CTRL bits
  localparam int CTRL_TXEN      = 0;
  localparam int CTRL_RXEN      = 1;
  localparam int CTRL_TXFLUSH   = 2;
  localparam int CTRL_RXFLUSH   = 3;
  localparam int CTRL_RXTHR_LSB = 8;

  // STATUS bits
  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;

  // INTSTAT / INTMASK bits
  localparam int INT_RXAV   = 0;
  localparam int INT_TXE    = 1;
  localparam int INT_TXDONE = 2;
  localparam int INT_OVR    = 3;
  localparam int INT_FE     = 4;
  localparam int INT_PE     = 5;
  localparam int INT_W      = 6;

  // Only these bits hold state and respond to write-1-to-clear
  localparam logic [INT_W-1:0] INT_STICKY_MASK = 6'b11_1100;

  // FRAME fields: {EPS,PEN,STOP,DLS[1:0]}
  localparam int FRAME_DLS_LSB = 0;
  localparam int FRAME_STOP    = 2;
  localparam int FRAME_PEN     = 3;
  localparam int FRAME_EPS     = 4;
  localparam int FRAME_W       = 5;

endpackage

// File: rtl/uart_apb_regfile_if.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile_if
//   APB3 completer-side bus bundle.
//   master: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave : the reverse
// ----------------------------------------------------------------------------
interface uart_apb_regfile_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_regfile_fifo.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile_fifo
//   Synchronous first-word-fall-through FIFO used for the UART TX and RX paths.
//   Ports:
//     clk, rst_n   clock, async active-low reset (pointers/count only)
//     flush        empties the FIFO at this edge; overrides wr and rd
//     wr, wr_data  push request; accepted when not full or when popping
//     rd           pop request; ignored when empty
//     rd_data      current head (valid while !empty)
//     empty, full  status
//     level        occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module uart_apb_regfile_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;

  // A pop on an empty FIFO is dropped; a push on a full FIFO only proceeds
  // if a pop frees a slot in the same cycle.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; empty/full come from the
  // pointers and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_apb_regfile.sv
// ----------------------------------------------------------------------------
// uart_apb_regfile
//   APB3 register file for the UART core: TX/RX FIFOs, byte-wide CSRs and
//   sticky, maskable, write-1-to-clear interrupt sources.
//   Ports:
//     PCLK, PRESETn             clock, async active-low reset
//     apb (slave modport)       APB3 bus, zero wait state
//     tx_valid/tx_data/tx_ready TX FIFO head towards the transmitter
//     tx_done                   pulse: character shifted out
//     rx_valid/rx_data/rx_*_err received character and error flags
//     baud_div, frame_cfg, rx_en configuration to the datapath
//     irq                       |(INTSTAT & INTMASK)
// ----------------------------------------------------------------------------
module uart_apb_regfile
  import uart_apb_regfile_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter int                BAUD_W     = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST   = BAUD_W'(103)
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  uart_apb_regfile_if.slave  apb,
  output logic               tx_valid,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               tx_ready,
  input  logic               tx_done,
  input  logic               rx_valid,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_frame_err,
  input  logic               rx_parity_err,
  output logic [BAUD_W-1:0]  baud_div,
  output logic [FRAME_W-1:0] frame_cfg,
  output logic               rx_en,
  output logic               irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [BAUD_W-1:0]  baud_q;
  logic               txen_q, rxen_q;
  logic [7:0]         rxthr_q;
  logic [FRAME_W-1:0] frame_q;
  logic [INT_W-1:0]   intmask_q;
  logic [INT_W-1:0]   sticky_q, sticky_d, sticky_set, w1c;
  logic [INT_W-1:0]   intstat;

  logic               access, wr_acc, rd_acc, ctrl_wr;
  logic [7:0]         addr;

  logic               tx_wr, tx_rd, tx_flush, tx_empty, tx_full;
  logic               rx_wr, rx_rd, rx_flush, rx_empty, rx_full;
  logic [DATA_W-1:0]  rx_head;
  logic [LW-1:0]      tx_level, rx_level;
  logic [7:0]         rx_thr_eff;
  logic               rxav;
  logic [31:0]        rdata;
  logic               slverr;
  logic               unused_apb;

  // One-cycle APB access phase; all side effects are keyed off it.
  assign access  = apb.PSEL & apb.PENABLE;
  assign addr    = apb.PADDR[7:0];
  assign wr_acc  = access & apb.PWRITE;
  assign rd_acc  = access & ~apb.PWRITE;
  assign ctrl_wr = wr_acc & (addr == REG_CTRL);

  assign unused_apb = ^{apb.PADDR[31:8], apb.PWDATA[31:16]};

  // ---------------- FIFOs ----------------
  assign tx_wr    = wr_acc & (addr == REG_TXDATA);
  assign tx_rd    = tx_valid & tx_ready;
  assign tx_flush = ctrl_wr & apb.PWDATA[CTRL_TXFLUSH];

  assign rx_wr    = rx_valid & rxen_q;
  assign rx_rd    = rd_acc & (addr == REG_RXDATA);
  assign rx_flush = ctrl_wr & apb.PWDATA[CTRL_RXFLUSH];

  uart_apb_regfile_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .flush   (tx_flush),
    .wr      (tx_wr),
    .wr_data (apb.PWDATA[DATA_W-1:0]),
    .rd      (tx_rd),
    .rd_data (tx_data),
    .empty   (tx_empty),
    .full    (tx_full),
    .level   (tx_level)
  );

  uart_apb_regfile_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .flush   (rx_flush),
    .wr      (rx_wr),
    .wr_data (rx_data),
    .rd      (rx_rd),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_full),
    .level   (rx_level)
  );

  assign tx_valid = txen_q & ~tx_empty;

  // ---------------- Interrupts ----------------
  // A threshold of 0 behaves like 1 so RXAV never fires on an empty FIFO.
  assign rx_thr_eff = (rxthr_q == 8'd0) ? 8'd1 : rxthr_q;
  assign rxav       = (32'(rx_level) >= 32'(rx_thr_eff));

  // NOTE: every variable written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sticky_set             = '0;
    sticky_set[INT_TXDONE] = tx_done;
    // An RX push into a full FIFO is lost unless a read frees a slot.
    sticky_set[INT_OVR]    = rx_wr & rx_full & ~rx_rd;
    sticky_set[INT_FE]     = rx_wr & rx_frame_err;
    sticky_set[INT_PE]     = rx_wr & rx_parity_err;

    w1c = '0;
    if (wr_acc && addr == REG_INTSTAT) w1c = apb.PWDATA[INT_W-1:0] & INT_STICKY_MASK;

    // Set after clear: a new event in the W1C cycle survives.
    sticky_d = (sticky_q & ~w1c) | sticky_set;

    intstat           = sticky_q;
    intstat[INT_RXAV] = rxav;
    intstat[INT_TXE]  = tx_empty;
  end

  assign irq = |(intstat & intmask_q);

  // ---------------- CSRs ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_q    <= BAUD_RST;
      txen_q    <= 1'b0;
      rxen_q    <= 1'b0;
      rxthr_q   <= '0;
      frame_q   <= '0;
      intmask_q <= '0;
      sticky_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (wr_acc) begin
        case (addr)
          REG_BAUD:    baud_q    <= apb.PWDATA[BAUD_W-1:0];
          REG_CTRL: begin
            txen_q  <= apb.PWDATA[CTRL_TXEN];
            rxen_q  <= apb.PWDATA[CTRL_RXEN];
            rxthr_q <= apb.PWDATA[CTRL_RXTHR_LSB +: 8];
          end
          REG_FRAME:   frame_q   <= apb.PWDATA[FRAME_W-1:0];
          REG_INTMASK: intmask_q <= apb.PWDATA[INT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign baud_div  = baud_q;
  assign frame_cfg = frame_q;
  assign rx_en     = rxen_q;

  // ---------------- Read mux / error ----------------
  // Gated by PRESETn so the bus reads back zero while reset is held.
  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    if (access && PRESETn) begin
      case (addr)
        REG_TXDATA:  slverr = apb.PWRITE & tx_full & ~tx_rd;
        REG_RXDATA: if (!apb.PWRITE) begin
          rdata  = rx_empty ? 32'd0 : 32'(rx_head);
          slverr = rx_empty;
        end
        REG_BAUD:    rdata = 32'(baud_q);
        REG_CTRL:    rdata = {16'd0, rxthr_q, 6'd0, rxen_q, txen_q};
        REG_FRAME:   rdata = 32'(frame_q);
        REG_STATUS:  rdata = 32'({tx_full, tx_empty, rx_full, rx_empty});
        REG_INTSTAT: rdata = 32'(intstat);
        REG_INTMASK: rdata = 32'(intmask_q);
        REG_LEVEL:   rdata = {16'd0, 8'(rx_level), 8'(tx_level)};
        default:     slverr = 1'b1;
      endcase
      if (apb.PWRITE) rdata = '0;
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PSLVERR = slverr;
  assign apb.PREADY  = 1'b1;

endmodule
